// File: rtl/can_tx_arbiter.sv
// CAN transmit mailbox arbiter: picks the lowest CAN arbitration key among pending mailboxes.
// Define CAN_TX_RETRY_LIMIT_EN to drop a mailbox after 16 consecutive transmit errors.
module can_tx_arbiter #(
    parameter  int NUM_MB = 4,
    localparam int SEL_W  = $clog2(NUM_MB)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_MB-1:0]        mb_req,
    input  logic [NUM_MB-1:0][10:0]  mb_id_std,
    input  logic [NUM_MB-1:0][17:0]  mb_id_ext,
    input  logic [NUM_MB-1:0]        mb_ide,
    input  logic [NUM_MB-1:0]        mb_rtr,
    input  logic [NUM_MB-1:0]        mb_abort,
    input  logic                     bus_idle,
    input  logic                     tx_done,
    input  logic                     tx_arb_lost,
    input  logic                     tx_error,
    output logic                     tx_start,
    output logic [SEL_W-1:0]         tx_sel,
    output logic [NUM_MB-1:0]        mb_pending,
    output logic [NUM_MB-1:0]        mb_done,
    output logic [NUM_MB-1:0]        mb_aborted,
    output logic [NUM_MB-1:0]        mb_failed,
    output logic [1:0]               fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SELECT = 2'd1, START = 2'd2, WAIT_TX = 2'd3} state_t;

    state_t             state, state_nxt;
    logic [NUM_MB-1:0]  pending, pending_nxt;
    logic [NUM_MB-1:0]  abort_def, abort_def_nxt;
    logic [NUM_MB-1:0]  done_nxt, aborted_nxt;
    logic [NUM_MB-1:0]  cand;
    logic [SEL_W-1:0]   win_idx;
    logic               win_found;
    logic [31:0]        best_key;
    logic               in_flight, done_ev, err_ev, lost_ev;

    // Bit order mirrors the on-wire arbitration field, so a numeric compare equals bus arbitration.
    function automatic logic [31:0] prio_key(input logic [10:0] id_s, input logic [17:0] id_e,
                                             input logic ide, input logic rtr);
        return {id_s, ide ? 1'b1 : rtr, ide, ide ? id_e : 18'd0, ide ? rtr : 1'b0};
    endfunction

    always_comb begin
        cand      = pending & ~mb_abort;
        win_idx   = '0;
        win_found = 1'b0;
        best_key  = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            // Strict less-than keeps the lowest index on equal keys.
            if (cand[i] && (!win_found ||
                prio_key(mb_id_std[i], mb_id_ext[i], mb_ide[i], mb_rtr[i]) < best_key)) begin
                win_found = 1'b1;
                best_key  = prio_key(mb_id_std[i], mb_id_ext[i], mb_ide[i], mb_rtr[i]);
                win_idx   = SEL_W'(i);
            end
        end
    end

    assign in_flight = (state == START) || (state == WAIT_TX);
    assign done_ev   = (state == WAIT_TX) && tx_done;
    assign err_ev    = (state == WAIT_TX) && !tx_done && tx_error;
    assign lost_ev   = (state == WAIT_TX) && !tx_done && !tx_error && tx_arb_lost;

`ifdef CAN_TX_RETRY_LIMIT_EN
    logic [NUM_MB-1:0][3:0] err_cnt, err_cnt_nxt;
    logic [NUM_MB-1:0]      failed_nxt;
`endif

    always_comb begin
        pending_nxt   = pending;
        abort_def_nxt = abort_def;
        done_nxt      = '0;
        aborted_nxt   = '0;
`ifdef CAN_TX_RETRY_LIMIT_EN
        err_cnt_nxt   = err_cnt;
        failed_nxt    = '0;
`endif
        for (int i = 0; i < NUM_MB; i++) begin
            if (mb_abort[i] && pending[i]) begin
                if (in_flight && tx_sel == SEL_W'(i)) begin
                    abort_def_nxt[i] = 1'b1;
                end else begin
                    pending_nxt[i] = 1'b0;
                    aborted_nxt[i] = 1'b1;
`ifdef CAN_TX_RETRY_LIMIT_EN
                    err_cnt_nxt[i] = '0;
`endif
                end
            end else if (mb_req[i] && !pending[i] && !mb_abort[i]) begin
                pending_nxt[i] = 1'b1;
`ifdef CAN_TX_RETRY_LIMIT_EN
                err_cnt_nxt[i] = '0;
`endif
            end

            if (tx_sel == SEL_W'(i)) begin
                if (done_ev) begin
                    pending_nxt[i]   = 1'b0;
                    done_nxt[i]      = 1'b1;
                    abort_def_nxt[i] = 1'b0;
`ifdef CAN_TX_RETRY_LIMIT_EN
                    err_cnt_nxt[i]   = '0;
`endif
                end else if ((err_ev || lost_ev) && (abort_def[i] || mb_abort[i])) begin
                    pending_nxt[i]   = 1'b0;
                    aborted_nxt[i]   = 1'b1;
                    abort_def_nxt[i] = 1'b0;
`ifdef CAN_TX_RETRY_LIMIT_EN
                    err_cnt_nxt[i]   = '0;
                end else if (err_ev) begin
                    if (err_cnt[i] == 4'd15) begin
                        pending_nxt[i] = 1'b0;
                        failed_nxt[i]  = 1'b1;
                        err_cnt_nxt[i] = '0;
                    end else begin
                        err_cnt_nxt[i] = err_cnt[i] + 4'd1;
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending && bus_idle) state_nxt = SELECT;
            SELECT:  state_nxt = win_found ? START : IDLE;
            START:   state_nxt = WAIT_TX;
            WAIT_TX: if (tx_done || tx_error || tx_arb_lost) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_sel     <= '0;
            pending    <= '0;
            abort_def  <= '0;
            mb_done    <= '0;
            mb_aborted <= '0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            abort_def  <= abort_def_nxt;
            mb_done    <= done_nxt;
            mb_aborted <= aborted_nxt;
            if (state == SELECT && win_found) tx_sel <= win_idx;
        end
    end

`ifdef CAN_TX_RETRY_LIMIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt   <= '0;
            mb_failed <= '0;
        end else begin
            err_cnt   <= err_cnt_nxt;
            mb_failed <= failed_nxt;
        end
    end
`else
    assign mb_failed = '0;
`endif

    assign tx_start   = (state == START);
    assign mb_pending = pending;
    assign fsm_state  = state;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Directed bench for can_tx_arbiter: expected events queued by the driver, popped by a monitor.
module tb_can_tx_arbiter;
    localparam int N = 4;
    localparam logic [3:0] EV_START = 4'd1, EV_DONE = 4'd2, EV_ABORT = 4'd3, EV_FAIL = 4'd4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       mb_req = '0;
    logic [N-1:0][10:0] mb_id_std = '0;
    logic [N-1:0][17:0] mb_id_ext = '0;
    logic [N-1:0]       mb_ide = '0;
    logic [N-1:0]       mb_rtr = '0;
    logic [N-1:0]       mb_abort = '0;
    logic               bus_idle = 1'b1;
    logic               tx_done = 1'b0, tx_arb_lost = 1'b0, tx_error = 1'b0;
    logic               tx_start;
    logic [1:0]         tx_sel;
    logic [N-1:0]       mb_pending, mb_done, mb_aborted, mb_failed;
    logic [1:0]         fsm_state;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0;

    can_tx_arbiter #(.NUM_MB(N)) dut (
        .clk(clk), .rst(rst), .mb_req(mb_req), .mb_id_std(mb_id_std), .mb_id_ext(mb_id_ext),
        .mb_ide(mb_ide), .mb_rtr(mb_rtr), .mb_abort(mb_abort), .bus_idle(bus_idle),
        .tx_done(tx_done), .tx_arb_lost(tx_arb_lost), .tx_error(tx_error),
        .tx_start(tx_start), .tx_sel(tx_sel), .mb_pending(mb_pending), .mb_done(mb_done),
        .mb_aborted(mb_aborted), .mb_failed(mb_failed), .fsm_state(fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
        mb_req = '0; mb_abort = '0; tx_done = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;
    endtask

    task automatic set_mb(input int i, input logic [10:0] s, input logic ide,
                          input logic [17:0] e, input logic rtr);
        mb_id_std[i] = s; mb_ide[i] = ide; mb_id_ext[i] = e; mb_rtr[i] = rtr;
    endtask

    task automatic push_ev(input logic [3:0] t, input int i);
        exp_q.push_back({t, 4'(i)});
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic req(input logic [N-1:0] m);
        mb_req = m;
        tick();
    endtask

    task automatic abort(input logic [N-1:0] m);
        mb_abort = m;
        tick();
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (!tx_start && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (!tx_start) begin
            errors++;
            $display("FAIL tx_start_timeout got=0 want=1");
        end
    endtask

    // kind: 0 done, 1 error, 2 arbitration lost; issued in the WAIT_TX cycle after START
    task automatic finish_tx(input int kind);
        tick();
        case (kind)
            0: tx_done = 1'b1;
            1: tx_error = 1'b1;
            default: tx_arb_lost = 1'b1;
        endcase
        tick();
    endtask

    // Scoreboard monitor
    task automatic sb_check(input logic [3:0] t, input int i);
        logic [7:0] got, want;
        got = {t, 4'(i)};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got=%h want=none", got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL sb_event got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_start) sb_check(EV_START, int'(tx_sel));
                for (int i = 0; i < N; i++) if (mb_done[i])    sb_check(EV_DONE, i);
                for (int i = 0; i < N; i++) if (mb_aborted[i]) sb_check(EV_ABORT, i);
                for (int i = 0; i < N; i++) if (mb_failed[i])  sb_check(EV_FAIL, i);
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) tick();
        rst = 1'b0;
        check_val("rst_state", 32'(fsm_state), 0);
        check_val("rst_tx_start", 32'(tx_start), 0);
        check_val("rst_tx_sel", 32'(tx_sel), 0);
        check_val("rst_pending", 32'(mb_pending), 0);
        check_val("rst_done", 32'(mb_done | mb_aborted | mb_failed), 0);

        // Single request: latency 3 cycles to tx_start
        set_mb(0, 11'h123, 1'b0, 18'h0, 1'b0);
        while (cyc < 10) tick();
        push_ev(EV_START, 0);
        mb_req = 4'b0001;
        c0 = cyc;
        tick();
        wait_start();
        check_val("latency", 32'(cyc - c0), 3);
        push_ev(EV_DONE, 0);
        finish_tx(0);
        check_val("pend_after_done", 32'(mb_pending), 0);

        // tx pulses while idle are ignored
        tx_done = 1'b1; tx_error = 1'b1; tx_arb_lost = 1'b1;
        tick();
        check_val("idle_pulse_state", 32'(fsm_state), 0);

        // Priority: MB3 std 0FF, MB1 std 100, MB2 ext std 100
        set_mb(1, 11'h100, 1'b0, 18'h0, 1'b0);
        set_mb(2, 11'h100, 1'b1, 18'h0, 1'b0);
        set_mb(3, 11'h0FF, 1'b0, 18'h0, 1'b0);
        req(4'b1110);
        check_val("pend_three", 32'(mb_pending), 32'hE);
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (k == 0) ? 3 : (k == 1) ? 1 : 2;
            push_ev(EV_START, idx);
            push_ev(EV_DONE, idx);
            wait_start();
            finish_tx(0);
        end

        // Equal keys: lowest index wins; then rtr=1 loses to rtr=0
        set_mb(0, 11'h200, 1'b0, 18'h0, 1'b0);
        set_mb(1, 11'h200, 1'b0, 18'h0, 1'b0);
        req(4'b0011);
        for (int k = 0; k < 2; k++) begin
            push_ev(EV_START, k);
            push_ev(EV_DONE, k);
            wait_start();
            finish_tx(0);
        end
        set_mb(1, 11'h200, 1'b0, 18'h0, 1'b1);
        set_mb(2, 11'h200, 1'b0, 18'h0, 1'b0);
        req(4'b0110);
        for (int k = 0; k < 2; k++) begin
            push_ev(EV_START, (k == 0) ? 2 : 1);
            push_ev(EV_DONE, (k == 0) ? 2 : 1);
            wait_start();
            finish_tx(0);
        end

        // Arbitration lost: newer lower-key request wins re-arbitration
        set_mb(1, 11'h300, 1'b0, 18'h0, 1'b0);
        set_mb(2, 11'h050, 1'b0, 18'h0, 1'b0);
        push_ev(EV_START, 1);
        req(4'b0010);
        wait_start();
        tick();
        req(4'b0100);
        tx_arb_lost = 1'b1;
        tick();
        check_val("pend_after_lost", 32'(mb_pending), 32'h6);
        push_ev(EV_START, 2); push_ev(EV_DONE, 2);
        push_ev(EV_START, 1); push_ev(EV_DONE, 1);
        wait_start(); finish_tx(0);
        wait_start(); finish_tx(0);

        // Deferred abort: done wins, error converts to abort
        set_mb(1, 11'h111, 1'b0, 18'h0, 1'b0);
        push_ev(EV_START, 1);
        req(4'b0010);
        wait_start();
        tick();
        abort(4'b0010);
        check_val("pend_deferred", 32'(mb_pending), 32'h2);
        push_ev(EV_DONE, 1);
        tx_done = 1'b1;
        tick();
        check_val("pend_abort_done", 32'(mb_pending), 0);
        push_ev(EV_START, 1);
        req(4'b0010);
        wait_start();
        tick();
        abort(4'b0010);
        push_ev(EV_ABORT, 1);
        tx_error = 1'b1;
        tick();
        check_val("pend_abort_err", 32'(mb_pending), 0);

        // Bus busy: duplicate request, abort of pending/non-pending, req+abort collision
        bus_idle = 1'b0;
        set_mb(0, 11'h123, 1'b0, 18'h0, 1'b0);
        req(4'b0001);
        req(4'b0001);
        check_val("pend_dup_req", 32'(mb_pending), 32'h1);
        req(4'b0100);
        push_ev(EV_ABORT, 2);
        abort(4'b0100);
        check_val("pend_abort_idle", 32'(mb_pending), 32'h1);
        abort(4'b0100);
        mb_req = 4'b1000; mb_abort = 4'b1000;
        tick();
        check_val("pend_req_abort", 32'(mb_pending), 32'h1);
        bus_idle = 1'b1;
        push_ev(EV_START, 0); push_ev(EV_DONE, 0);
        wait_start(); finish_tx(0);

        // Reset while transmitting drops the frame silently
        set_mb(1, 11'h222, 1'b0, 18'h0, 1'b0);
        push_ev(EV_START, 1);
        req(4'b0010);
        wait_start();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tx_done = 1'b1;
        tick();
        check_val("pend_after_rst", 32'(mb_pending), 0);
        check_val("state_after_rst", 32'(fsm_state), 0);

        // Sixteen consecutive errors on MB0
        set_mb(0, 11'h010, 1'b0, 18'h0, 1'b0);
        req(4'b0001);
        for (int k = 0; k < 16; k++) begin
            push_ev(EV_START, 0);
`ifdef CAN_TX_RETRY_LIMIT_EN
            if (k == 15) push_ev(EV_FAIL, 0);
`endif
            wait_start();
            finish_tx(1);
        end
`ifdef CAN_TX_RETRY_LIMIT_EN
        check_val("pend_retry_fail", 32'(mb_pending), 0);
`else
        check_val("pend_retry_keep", 32'(mb_pending), 32'h1);
        push_ev(EV_START, 0); push_ev(EV_DONE, 0);
        wait_start(); finish_tx(0);
`endif

        repeat (5) tick();
        check_val("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
